muldiv_unit: RTL

Iterative 32-bit multiply/divide execute unit, directly downstream of the register file read stage.
- Consumes the two registered read operands and a destination index.
- Runs a fixed-latency shift/add (multiply) or restoring subtract (divide) sequence.
- Issues a single-cycle write-back request (wb_en/wb_sel/wb_data) that drives the register file's write port.
- Fixed latency for every op, so the control unit stalls deterministically on busy.

---
 rtl/muldiv_unit_pkg.sv | 21 ++
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_core.sv | 44 ++++
 rtl/muldiv_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared widths, op/state encodings and op-class helpers
//   for the multiply/divide unit, register file and control unit.
package muldiv_unit_pkg;
    localparam int MD_WIDTH  = 32;
    localparam int MD_ADDR_W = 5;
    localparam int MD_CNT_W  = 6;

    typedef enum logic [2:0] {
        OP_MULLO, OP_MULHI, OP_MULHIU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_RSVD
    } op_e;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    function automatic logic is_signed_op(op_e op);
        return op inside {OP_MULHI, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div_op(op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/write-back bundle between control, muldiv_unit and register file.
//   master: start, op, opa, opb, dest, flush out; busy and write-back in.
//   slave : the reverse (the execute unit).
interface muldiv_unit_if import muldiv_unit_pkg::*; #(
    parameter int WIDTH  = MD_WIDTH,
    parameter int ADDR_W = MD_ADDR_W
);
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic [ADDR_W-1:0] dest;
    logic              flush;
    logic              busy;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_sel;
    logic [WIDTH-1:0]  wb_data;
    logic              div_by_zero;

    modport master (
        output start, op, opa, opb, dest, flush,
        input  busy, wb_en, wb_sel, wb_data, div_by_zero
    );
    modport slave (
        input  start, op, opa, opb, dest, flush,
        output busy, wb_en, wb_sel, wb_data, div_by_zero
    );
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: one shift-add / restoring-subtract iteration plus sign fix and result select.
//   in : op, sign flags sa/sb, dz (zero divisor), hi/lo working pair, b (multiplicand/divisor magnitude)
//   out: hi_n/lo_n (next iteration), result (signed, field-selected write-back value)
module muldiv_core import muldiv_unit_pkg::*; #(
    parameter int WIDTH = MD_WIDTH
) (
    input  op_e              op,
    input  logic             sa,
    input  logic             sb,
    input  logic             dz,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH:0]     sum, sh, diff;
    logic               ge, div;
    logic [2*WIDTH-1:0] prod, sprod;
    logic [WIDTH-1:0]   q, r;

    // Multiply: {hi,lo} holds partial product over multiplier; divide: hi is the
    // partial remainder, lo shifts the dividend out and the quotient in.
    // The remainder never reaches b, so the doubled value minus b fits WIDTH bits
    // whenever it is non-negative; bit WIDTH of diff is therefore the borrow.
    always_comb begin
        div    = is_div_op(op);
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        sh     = {hi, lo[WIDTH-1]};
        diff   = sh - {1'b0, b};
        ge     = !diff[WIDTH];
        hi_n   = div ? (ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0]) : sum[WIDTH:1];
        lo_n   = div ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
        prod   = {hi, lo};
        sprod  = (sa ^ sb) ? -prod : prod;
        q      = dz ? '1 : (sa ^ sb) ? -lo : lo;
        r      = sa ? -hi : hi;
        result = op == OP_RSVD ? '0 :
                 op == OP_MULLO ? lo :
                 (op == OP_MULHI || op == OP_MULHIU) ? sprod[2*WIDTH-1:WIDTH] :
                 (op == OP_DIV || op == OP_DIVU) ? q : r;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: fixed-latency iterative 32-bit multiply/divide execute unit.
//   clk, rst (async, active-high); bus (slave): start/op/opa/opb/dest/flush in,
//   busy and registered write-back wb_en/wb_sel/wb_data/div_by_zero out.
module muldiv_unit import muldiv_unit_pkg::*; #(
    parameter int WIDTH  = MD_WIDTH,
    parameter int ADDR_W = MD_ADDR_W,
    parameter int CNT_W  = MD_CNT_W
) (
    input logic           clk,
    input logic           rst,
    muldiv_unit_if.slave  bus
);
    state_e            state, state_n;
    logic [CNT_W-1:0]  cnt;
    op_e               op_q, in_op;
    logic [ADDR_W-1:0] dest_q, wb_sel_n;
    logic [WIDTH-1:0]  hi, lo, b, hi_n, lo_n, result, mag_a, mag_b, wb_data_n;
    logic              sa, sb, dz, in_sa, in_sb, accept, last, wb_en_n, dz_n;

    always_comb begin
        in_op  = op_e'(bus.op);
        in_sa  = is_signed_op(in_op) && bus.opa[WIDTH-1];
        in_sb  = is_signed_op(in_op) && bus.opb[WIDTH-1];
        mag_a  = in_sa ? -bus.opa : bus.opa;
        mag_b  = in_sb ? -bus.opb : bus.opb;
        accept = state == IDLE && bus.start && !bus.flush;
        last   = cnt == CNT_W'(WIDTH - 1);
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .op(op_q), .sa(sa), .sb(sb), .dz(dz), .hi(hi), .lo(lo), .b(b),
        .hi_n(hi_n), .lo_n(lo_n), .result(result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = (bus.flush || state == DONE) ? IDLE :
                  state == IDLE ? (bus.start ? CALC : IDLE) :
                  state == CALC ? (last ? FIX : CALC) : DONE;
    end

    // Write-back values are loaded on the FIX->DONE edge so they are visible during DONE.
    always_comb begin
        bus.busy  = state != IDLE;
        wb_en_n   = state == FIX && !bus.flush;
        wb_sel_n  = wb_en_n ? dest_q : bus.wb_sel;
        wb_data_n = wb_en_n ? result : bus.wb_data;
        dz_n      = wb_en_n && dz;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= OP_MULLO;
            dest_q <= '0;
            hi     <= '0;
            lo     <= '0;
            b      <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz     <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= in_op;
            dest_q <= bus.dest;
            hi     <= '0;
            lo     <= mag_a;
            b      <= mag_b;
            sa     <= in_sa;
            sb     <= in_sb;
            dz     <= is_div_op(in_op) && bus.opb == '0;
        end else if (state == CALC) begin
            cnt    <= cnt + CNT_W'(1);
            hi     <= hi_n;
            lo     <= lo_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_en       <= 1'b0;
            bus.wb_sel      <= '0;
            bus.wb_data     <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.wb_en       <= wb_en_n;
            bus.wb_sel      <= wb_sel_n;
            bus.wb_data     <= wb_data_n;
            bus.div_by_zero <= dz_n;
        end
    end
endmodule
